// File: rtl/pin_pkg.sv
`default_nettype none
// ============================================================================
// pin_pkg : action codes, key codes and state type for the PIN keypad front end
// Rev 1.0
// ============================================================================
package pin_pkg;

  // Action codes shared with the session FSM
  localparam logic [4:0] ACT_IDLE     = 5'b00000;
  localparam logic [4:0] ACT_WAIT_PIN = 5'b00011;
  localparam logic [4:0] ACT_PIN_SUB  = 5'b00100;
  localparam logic [4:0] ACT_MENU     = 5'b00101;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;
  localparam logic [3:0] KEY_CAN = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_SUBMIT  = 3'd2,
    ST_RESULT  = 3'd3,
    ST_LOCKED  = 3'd4
  } pin_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pin_entry_ctrl_if.sv
`default_nettype none
// ============================================================================
// pin_entry_ctrl_if : keypad / FSM-side signals of the PIN entry front end
// Rev 1.0
// ============================================================================
interface pin_entry_ctrl_if;

  logic       key_valid;
  logic [3:0] key_code;
  logic [4:0] action;
  logic       ep;
  logic [3:0] InPass;
  logic       cnl_req;
  logic       locked;
  logic [2:0] digit_cnt;

  modport master (
    output key_valid, key_code, action,
    input  ep, InPass, cnl_req, locked, digit_cnt
  );

  modport slave (
    input  key_valid, key_code, action,
    output ep, InPass, cnl_req, locked, digit_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pin_timeout_timer.sv
`default_nettype none
// ============================================================================
// pin_timeout_timer : reloadable down-counter, expire flags the last idle cycle
// Rev 1.0
// ============================================================================
module pin_timeout_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic en,
  output logic      expire
);

  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The count holds the idle cycles still allowed; zero means this is the last one
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pin_entry_ctrl.sv
`default_nettype none
// ============================================================================
// pin_entry_ctrl : assembles keypad digits into InPass, strobes ep, and
//                  enforces retry limit and inactivity timeout via cnl_req
// Rev 1.0
// ============================================================================
module pin_entry_ctrl
  import pin_pkg::*;
#(
  parameter int PIN_DIGITS  = 2,
  parameter int ACC_W       = 7,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input  wire logic       clk,
  input  wire logic       CNL,
  pin_entry_ctrl_if.slave bus
);

  localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [2:0]       DIGITS_C  = 3'(PIN_DIGITS);
  localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);

  pin_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [3:0]       inpass_q, inpass_d;
  logic [2:0]       digit_cnt_q, digit_cnt_d;
  logic             ep_q, ep_d;
  logic             cnl_req_q, cnl_req_d;
  logic             locked_q, locked_d;

  logic             key_digit, key_clr, key_ent, key_can;
  logic             wait_pin, act_menu;
  logic [TRY_W-1:0] tries_inc;
  logic             tmr_clr, tmr_en, tmr_expire;

  assign key_digit = bus.key_valid && is_digit(bus.key_code);
  assign key_clr   = bus.key_valid && (bus.key_code == KEY_CLR);
  assign key_ent   = bus.key_valid && (bus.key_code == KEY_ENT);
  assign key_can   = bus.key_valid && (bus.key_code == KEY_CAN);
  assign wait_pin  = (bus.action == ACT_WAIT_PIN);
  assign act_menu  = (bus.action == ACT_MENU);
  assign tries_inc = tries_q + 1'b1;

  // Any key press restarts the idle window; outside COLLECT it stays parked at full
  assign tmr_clr = (state_q != ST_COLLECT) || bus.key_valid;
  assign tmr_en  = (state_q == ST_COLLECT) && !bus.key_valid;

  pin_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (CNL),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or posedge CNL) begin
    if (CNL) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      tries_q     <= '0;
      inpass_q    <= '0;
      digit_cnt_q <= '0;
      ep_q        <= 1'b0;
      cnl_req_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tries_q     <= tries_d;
      inpass_q    <= inpass_d;
      digit_cnt_q <= digit_cnt_d;
      ep_q        <= ep_d;
      cnl_req_q   <= cnl_req_d;
      locked_q    <= locked_d;
    end
  end

  // Cancel key and timeout outrank the FSM walking away from the PIN stage
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wait_pin) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (key_can || tmr_expire) begin
          state_d = ST_IDLE;
        end else if (!wait_pin) begin
          state_d = ST_IDLE;
        end else if (key_ent && (digit_cnt_q == DIGITS_C)) begin
          state_d = ST_SUBMIT;
        end
      end
      ST_SUBMIT: begin
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (act_menu) begin
          state_d = ST_IDLE;
        end else if (wait_pin) begin
          state_d = (tries_inc == TRIES_MAX) ? ST_LOCKED : ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    tries_d     = tries_q;
    inpass_d    = inpass_q;
    digit_cnt_d = digit_cnt_q;
    ep_d        = 1'b0;
    cnl_req_d   = 1'b0;
    locked_d    = locked_q;
    case (state_q)
      ST_COLLECT: begin
        if (key_can || tmr_expire) begin
          cnl_req_d = 1'b1;
          tries_d   = '0;
        end else if (state_d == ST_SUBMIT) begin
          inpass_d = acc_q[3:0];
          ep_d     = 1'b1;
        end else if (state_d == ST_COLLECT) begin
          if (key_clr) begin
            acc_d       = '0;
            digit_cnt_d = '0;
          end else if (key_digit && (digit_cnt_q < DIGITS_C)) begin
            acc_d       = (acc_q * ACC_W'(10)) + ACC_W'(bus.key_code);
            digit_cnt_d = digit_cnt_q + 3'd1;
          end
        end
      end
      ST_RESULT: begin
        if (act_menu) begin
          tries_d = '0;
        end else if (wait_pin) begin
          tries_d = tries_inc;
          if (state_d == ST_LOCKED) begin
            cnl_req_d = 1'b1;
            locked_d  = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
    // A partial entry never survives leaving the PIN stage or a failed attempt
    if ((state_d == ST_IDLE) || (state_d == ST_LOCKED) ||
        ((state_q == ST_RESULT) && (state_d == ST_COLLECT))) begin
      acc_d       = '0;
      digit_cnt_d = '0;
    end
  end

  assign bus.ep        = ep_q;
  assign bus.InPass    = inpass_q;
  assign bus.cnl_req   = cnl_req_q;
  assign bus.locked    = locked_q;
  assign bus.digit_cnt = digit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pin_entry_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pin_entry_ctrl : directed scenarios plus random keypad traffic vs. model
// Rev 1.0
// ============================================================================
module tb_pin_entry_ctrl;
  import pin_pkg::*;

  localparam int PD = 2;
  localparam int MT = 3;
  localparam int TO = 8;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_SUBMIT = 2, M_RESULT = 3, M_LOCKED = 4;

  logic clk = 1'b0;
  logic CNL = 1'b1;
  always #5 clk = ~clk;

  pin_entry_ctrl_if bus ();

  pin_entry_ctrl #(
    .PIN_DIGITS  (PD),
    .ACC_W       (7),
    .MAX_TRIES   (MT),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .CNL (CNL),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode, digits typed so far, idle cycles since entry/last key
  int         m_mode;
  int         m_idle;
  int         m_tries;
  int         m_digits[$];
  logic       m_ep, m_cnl, m_locked;
  logic [3:0] m_inpass;

  task automatic model_reset();
    m_mode = M_IDLE; m_idle = 0; m_tries = 0; m_digits.delete();
    m_ep = 1'b0; m_cnl = 1'b0; m_locked = 1'b0; m_inpass = 4'h0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kc, input logic [4:0] act);
    int v;
    m_ep = 1'b0;
    m_cnl = 1'b0;
    case (m_mode)
      M_IDLE: if (act == ACT_WAIT_PIN) begin
        m_mode = M_COLLECT; m_idle = 0; m_digits.delete();
      end
      M_COLLECT: begin
        if ((kv && kc == KEY_CAN) || (!kv && m_idle == TO - 1)) begin
          m_cnl = 1'b1; m_tries = 0; m_mode = M_IDLE; m_digits.delete();
        end else if (act != ACT_WAIT_PIN) begin
          m_mode = M_IDLE; m_digits.delete();
        end else if (!kv) begin
          m_idle++;
        end else begin
          m_idle = 0;
          if (kc <= 4'd9) begin
            if (m_digits.size() < PD) m_digits.push_back(int'(kc));
          end else if (kc == KEY_CLR) begin
            m_digits.delete();
          end else if (kc == KEY_ENT && m_digits.size() == PD) begin
            v = 0;
            foreach (m_digits[i]) v = v * 10 + m_digits[i];
            m_inpass = 4'(v % 16); m_ep = 1'b1; m_mode = M_SUBMIT;
          end
        end
      end
      M_SUBMIT: m_mode = M_RESULT;
      M_RESULT: begin
        m_digits.delete(); m_idle = 0;
        if (act == ACT_MENU) begin
          m_tries = 0; m_mode = M_IDLE;
        end else if (act == ACT_WAIT_PIN) begin
          m_tries++;
          if (m_tries == MT) begin
            m_mode = M_LOCKED; m_cnl = 1'b1; m_locked = 1'b1;
          end else begin
            m_mode = M_COLLECT;
          end
        end else begin
          m_mode = M_IDLE;
        end
      end
      default: ;
    endcase
  endtask

  // One clock: inputs set away from the edge, outputs sampled 1 time unit after it
  task automatic tick(input logic kv, input logic [3:0] kc, input logic [4:0] act);
    bus.key_valid = kv; bus.key_code = kc; bus.action = act;
    @(posedge clk);
    model_step(kv, kc, act);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] kc);
    tick(1'b1, kc, ACT_WAIT_PIN);
  endtask

  task automatic test_reset();
    bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.action = ACT_IDLE;
    CNL = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.ep !== 1'b0)        begin miscompares++; $display("FAIL reset_ep: got %b want 0", bus.ep); end
    vectors++; if (bus.InPass !== 4'h0)    begin miscompares++; $display("FAIL reset_inpass: got %h want 0", bus.InPass); end
    vectors++; if (bus.cnl_req !== 1'b0)   begin miscompares++; $display("FAIL reset_cnl: got %b want 0", bus.cnl_req); end
    vectors++; if (bus.locked !== 1'b0)    begin miscompares++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    vectors++; if (bus.digit_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", bus.digit_cnt); end
    CNL = 1'b0;
  endtask

  task automatic test_success();
    tick(1'b0, 4'h0, ACT_WAIT_PIN);
    press(4'd1); press(4'd5); press(KEY_ENT);
    vectors++; if (bus.ep !== 1'b1)     begin miscompares++; $display("FAIL ok_ep: got %b want 1", bus.ep); end
    vectors++; if (bus.InPass !== 4'hF) begin miscompares++; $display("FAIL ok_inpass: got %h want f", bus.InPass); end
    tick(1'b0, 4'h0, ACT_PIN_SUB);
    vectors++; if (bus.ep !== 1'b0)     begin miscompares++; $display("FAIL ok_ep_once: got %b want 0", bus.ep); end
    vectors++; if (bus.InPass !== 4'hF) begin miscompares++; $display("FAIL ok_inpass_hold: got %h want f", bus.InPass); end
    tick(1'b0, 4'h0, ACT_MENU);
    vectors++; if (bus.cnl_req !== 1'b0) begin miscompares++; $display("FAIL ok_no_cnl: got %b want 0", bus.cnl_req); end
    vectors++; if (bus.digit_cnt !== 3'd0) begin miscompares++; $display("FAIL ok_cnt: got %0d want 0", bus.digit_cnt); end
  endtask

  task automatic test_lockout();
    tick(1'b0, 4'h0, ACT_WAIT_PIN);
    for (int i = 0; i < MT; i++) begin
      press(4'd2); press(4'd3); press(KEY_ENT);
      vectors++; if (bus.ep !== 1'b1 || bus.InPass !== 4'h7) begin
        miscompares++; $display("FAIL lock_submit%0d: got ep=%b pin=%h want ep=1 pin=7", i, bus.ep, bus.InPass);
      end
      tick(1'b0, 4'h0, ACT_WAIT_PIN);
      tick(1'b0, 4'h0, ACT_WAIT_PIN);
      vectors++; if (bus.locked !== (i == MT - 1) || bus.cnl_req !== (i == MT - 1)) begin
        miscompares++; $display("FAIL lock_verdict%0d: got locked=%b cnl=%b want %0d", i, bus.locked, bus.cnl_req, i == MT - 1);
      end
    end
    tick(1'b0, 4'h0, ACT_WAIT_PIN);
    vectors++; if (bus.cnl_req !== 1'b0 || bus.locked !== 1'b1) begin
      miscompares++; $display("FAIL lock_hold: got cnl=%b locked=%b want cnl=0 locked=1", bus.cnl_req, bus.locked);
    end
    press(4'd2); press(4'd3); press(KEY_ENT);
    vectors++; if (bus.ep !== 1'b0) begin miscompares++; $display("FAIL lock_no_ep: got %b want 0", bus.ep); end
    #2; CNL = 1'b1; #1;
    model_reset();
    vectors++; if ({bus.ep, bus.InPass, bus.cnl_req, bus.locked, bus.digit_cnt} !== 10'd0) begin
      miscompares++; $display("FAIL lock_cnl: got ep=%b pin=%h cnl=%b locked=%b cnt=%0d want all 0",
                              bus.ep, bus.InPass, bus.cnl_req, bus.locked, bus.digit_cnt);
    end
    @(negedge clk); CNL = 1'b0;
  endtask

  task automatic test_short_and_clear();
    tick(1'b0, 4'h0, ACT_WAIT_PIN);
    press(4'd4); press(KEY_ENT);
    vectors++; if (bus.ep !== 1'b0 || bus.digit_cnt !== 3'd1) begin
      miscompares++; $display("FAIL short_ent: got ep=%b cnt=%0d want ep=0 cnt=1", bus.ep, bus.digit_cnt);
    end
    press(4'd2); press(KEY_CLR);
    vectors++; if (bus.digit_cnt !== 3'd0) begin miscompares++; $display("FAIL clr_cnt: got %0d want 0", bus.digit_cnt); end
    press(4'd1); press(4'd5); press(KEY_ENT);
    vectors++; if (bus.ep !== 1'b1 || bus.InPass !== 4'hF) begin
      miscompares++; $display("FAIL clr_submit: got ep=%b pin=%h want ep=1 pin=f", bus.ep, bus.InPass);
    end
    tick(1'b0, 4'h0, ACT_PIN_SUB);
    vectors++; if (bus.ep !== 1'b0) begin miscompares++; $display("FAIL clr_ep_once: got %b want 0", bus.ep); end
    tick(1'b0, 4'h0, ACT_MENU);
  endtask

  task automatic test_timeout();
    tick(1'b0, 4'h0, ACT_WAIT_PIN);
    for (int k = 1; k <= TO; k++) begin
      tick(1'b0, 4'h0, ACT_WAIT_PIN);
      vectors++; if (bus.cnl_req !== (k == TO)) begin
        miscompares++; $display("FAIL timeout_k%0d: got cnl=%b want %0d", k, bus.cnl_req, k == TO);
      end
    end
    tick(1'b0, 4'h0, ACT_WAIT_PIN);
    repeat (TO - 1) tick(1'b0, 4'h0, ACT_WAIT_PIN);
    press(4'd3);
    vectors++; if (bus.cnl_req !== 1'b0 || bus.digit_cnt !== 3'd1) begin
      miscompares++; $display("FAIL timeout_key_wins: got cnl=%b cnt=%0d want cnl=0 cnt=1", bus.cnl_req, bus.digit_cnt);
    end
  endtask

  task automatic test_cancel_abort();
    press(4'd7);
    press(KEY_CAN);
    vectors++; if (bus.cnl_req !== 1'b1 || bus.digit_cnt !== 3'd0) begin
      miscompares++; $display("FAIL cancel: got cnl=%b cnt=%0d want cnl=1 cnt=0", bus.cnl_req, bus.digit_cnt);
    end
    tick(1'b1, 4'd5, ACT_IDLE);
    vectors++; if (bus.cnl_req !== 1'b0 || bus.digit_cnt !== 3'd0) begin
      miscompares++; $display("FAIL cancel_idle: got cnl=%b cnt=%0d want cnl=0 cnt=0", bus.cnl_req, bus.digit_cnt);
    end
    tick(1'b0, 4'h0, ACT_WAIT_PIN);
    press(4'd9);
    tick(1'b0, 4'h0, ACT_IDLE);
    vectors++; if (bus.cnl_req !== 1'b0) begin miscompares++; $display("FAIL abort_no_cnl: got %b want 0", bus.cnl_req); end
    tick(1'b1, 4'd1, ACT_IDLE);
    vectors++; if (bus.cnl_req !== 1'b0 || bus.digit_cnt !== 3'd0) begin
      miscompares++; $display("FAIL abort_idle: got cnl=%b cnt=%0d want cnl=0 cnt=0", bus.cnl_req, bus.digit_cnt);
    end
  endtask

  task automatic test_cnl_submit();
    tick(1'b0, 4'h0, ACT_WAIT_PIN);
    press(4'd8); press(4'd6); press(KEY_ENT);
    vectors++; if (bus.ep !== 1'b1 || bus.InPass !== 4'h6) begin
      miscompares++; $display("FAIL sub86: got ep=%b pin=%h want ep=1 pin=6", bus.ep, bus.InPass);
    end
    #2; CNL = 1'b1; #1;
    model_reset();
    vectors++; if ({bus.ep, bus.InPass, bus.cnl_req, bus.locked, bus.digit_cnt} !== 10'd0) begin
      miscompares++; $display("FAIL submit_cnl: got ep=%b pin=%h cnl=%b locked=%b cnt=%0d want all 0",
                              bus.ep, bus.InPass, bus.cnl_req, bus.locked, bus.digit_cnt);
    end
    @(negedge clk); CNL = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] act;
    logic       kv;
    logic [3:0] kc;
    int         r;
    act = ACT_WAIT_PIN;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 6) begin
        r = $urandom_range(0, 9);
        act = (r < 6) ? ACT_WAIT_PIN : (r < 8) ? ACT_MENU : (r < 9) ? ACT_IDLE : ACT_PIN_SUB;
      end
      kv = ($urandom_range(0, 99) < 40);
      kc = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      if ($urandom_range(0, 299) == 0 || (m_mode == M_LOCKED && $urandom_range(0, 9) == 0)) begin
        #2; CNL = 1'b1; #1;
        model_reset();
        @(negedge clk); CNL = 1'b0;
      end
      tick(kv, kc, act);
      vectors++; if (bus.ep !== m_ep) begin
        miscompares++; $display("FAIL rnd_ep c%0d: got %b want %b", c, bus.ep, m_ep);
      end
      vectors++; if (bus.InPass !== m_inpass) begin
        miscompares++; $display("FAIL rnd_inpass c%0d: got %h want %h", c, bus.InPass, m_inpass);
      end
      vectors++; if (bus.cnl_req !== m_cnl) begin
        miscompares++; $display("FAIL rnd_cnl c%0d: got %b want %b", c, bus.cnl_req, m_cnl);
      end
      vectors++; if (bus.locked !== m_locked) begin
        miscompares++; $display("FAIL rnd_locked c%0d: got %b want %b", c, bus.locked, m_locked);
      end
      vectors++; if (bus.digit_cnt !== 3'(m_digits.size())) begin
        miscompares++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, bus.digit_cnt, m_digits.size());
      end
      vectors++; if ((bus.ep & bus.cnl_req) !== 1'b0) begin
        miscompares++; $display("FAIL rnd_excl c%0d: got ep=%b cnl=%b want not both", c, bus.ep, bus.cnl_req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_success();
    test_lockout();
    test_short_and_clear();
    test_timeout();
    test_cancel_abort();
    test_cnl_submit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
